// File: rtl/matbi_peri_pkg.sv
// Shared definitions for the matbi peripheral masters: FSM state encodings and
// output-buffer sizing.
package matbi_peri_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = 2;

endpackage

// File: rtl/matbi_rd_obuf.sv
// Two-entry in-order output buffer feeding a valid/ready stream; a push and a
// pop may happen in the same cycle.
module matbi_rd_obuf
    import matbi_peri_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [OCC_WIDTH-1:0]  occ
);

    logic [DATA_WIDTH-1:0] ent [OBUF_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [OCC_WIDTH-1:0]  occ_q;
    logic                  pop;
    logic                  push_ok;

    assign pop     = m_valid & m_ready;
    // Upstream credit logic keeps this from ever dropping a word; the guard only protects state.
    assign push_ok = push & ((occ_q != OCC_WIDTH'(OBUF_DEPTH)) | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) ent[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= '0;
        end else begin
            if (push_ok) begin
                ent[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push_ok, pop})
                2'b10:   occ_q <= occ_q + OCC_WIDTH'(1);
                2'b01:   occ_q <= occ_q - OCC_WIDTH'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign m_valid = (occ_q != '0);
    assign m_data  = ent[rd_ptr];
    assign occ     = occ_q;

endmodule

// File: rtl/matbi_bram_stream_reader.sv
// Drains a block of words from a 1-cycle-latency BRAM port and emits them as a
// valid/ready stream, with credit-based issue so backpressure never loses data.
module matbi_bram_stream_reader
    import matbi_peri_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_num,
    output logic                  o_idle,
    output logic                  o_running,
    output logic                  o_done,
    output logic                  o_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  num_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  popped;
    logic [LEN_WIDTH-1:0]  popped_nxt;
    logic                  inflight;
    logic [OCC_WIDTH-1:0]  occ;
    logic [OCC_WIDTH-1:0]  outstanding;
    logic                  hs;
    logic                  credit;
    logic                  start;

    matbi_rd_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (inflight),
        .push_data(i_rdata),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .occ      (occ)
    );

    assign hs          = m_valid & m_ready;
    assign start       = (state == S_IDLE) & i_run;
    assign popped_nxt  = popped + LEN_WIDTH'(hs);
    assign outstanding = occ + OCC_WIDTH'(inflight);
    // A slot frees up this cycle if the head word is handed off, so issue may proceed at full depth.
    assign credit      = (outstanding < OCC_WIDTH'(OBUF_DEPTH)) |
                         ((outstanding == OCC_WIDTH'(OBUF_DEPTH)) & hs);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_en      = 1'b0;
        o_addr    = '0;
        unique case (state)
            S_IDLE: if (i_run) state_nxt = S_RUN;
            S_RUN: begin
                o_en = (issued < num_q) & credit;
                if (o_en) o_addr = base_q + ADDR_WIDTH'(issued);
                if (popped_nxt == num_q) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run parameters and transfer counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            num_q    <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_en;
            if (start) begin
                base_q <= i_base_addr;
                num_q  <= i_num;
                issued <= '0;
                popped <= '0;
            end else begin
                if (o_en) issued <= issued + LEN_WIDTH'(1);
                if (hs)   popped <= popped_nxt;
            end
        end
    end

    assign o_idle    = (state == S_IDLE);
    assign o_running = (state == S_RUN);
    assign o_done    = (state == S_DONE);

endmodule
